// File: rtl/value_writer.sv
// value_writer: per-channel value FIFOs drained round-robin into a single
// registered RAM write port. Each channel fills its own contiguous RAM region
// (base + chan_len words) and raises a sticky done flag when that region is full.
// Optional: define VALUE_WRITER_OVERFLOW_EN to build sticky push-while-full flags;
// without it the overflow outputs are tied low.

// Per-channel lane: FIFO storage, region address/count tracking, done/overflow.
module value_writer_lane #(
  parameter int                   val_bits       = 8,
  parameter int                   addr_bits      = 13,
  parameter int                   fifo_depth_log = 4,
  parameter int                   chan_len       = 1024,
  parameter logic [addr_bits-1:0] base           = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write,
  input  logic [val_bits-1:0]  in,
  input  logic                 pop,
  output logic                 full,
  output logic                 req,
  output logic [val_bits-1:0]  head,
  output logic [addr_bits-1:0] addr,
  output logic                 done,
  output logic                 overflow
);
  localparam int depth = 1 << fifo_depth_log;

  logic [val_bits-1:0]       mem [depth];
  logic [fifo_depth_log-1:0] wr_ptr, rd_ptr;
  logic [fifo_depth_log:0]   count;
  logic [addr_bits:0]        cnt;
  logic                      push;

  // A push against a full FIFO is dropped even if the same edge pops it.
  assign push = write && !full;
  assign full = (count == (fifo_depth_log+1)'(depth));
  assign req  = (count != '0) && !done;
  assign head = mem[rd_ptr];

  // FIFO storage; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= in;
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Region tracking: next RAM address (wraps), words written, completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr <= base;
      cnt  <= '0;
      done <= 1'b0;
    end else if (pop) begin
      addr <= addr + 1'b1;
      cnt  <= cnt + 1'b1;
      if (cnt == (addr_bits+1)'(chan_len - 1)) done <= 1'b1;
    end
  end

`ifdef VALUE_WRITER_OVERFLOW_EN
  // Sticky record of any push attempted while full.
  always_ff @(posedge clk) begin
    if (!rst)              overflow <= 1'b0;
    else if (write && full) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

module value_writer #(
  parameter int                               channel_num     = 8,
  parameter int                               channel_num_log = 3,
  parameter int                               val_bits        = 8,
  parameter int                               addr_bits       = 13,
  parameter int                               fifo_depth_log  = 4,
  parameter logic [channel_num*addr_bits-1:0] base_addr       = {8{13'd0}},
  parameter int                               chan_len        = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [channel_num-1:0]          write,
  input  logic [val_bits*channel_num-1:0] in,
  output logic [channel_num-1:0]          full,
  output logic                            ram_we,
  output logic [addr_bits-1:0]            ram_addr,
  output logic [val_bits-1:0]             ram_din,
  output logic [channel_num-1:0]          done,
  output logic                            all_done,
  output logic [channel_num-1:0]          overflow
);
  logic [channel_num-1:0]                req, grant;
  logic [channel_num-1:0][val_bits-1:0]  head;
  logic [channel_num-1:0][addr_bits-1:0] addr;
  logic [channel_num_log-1:0]            ptr, gidx, scan;
  logic                                  gvld;

  genvar i;
  generate
    for (i = 0; i < channel_num; i++) begin : g_lane
      value_writer_lane #(
        .val_bits       (val_bits),
        .addr_bits      (addr_bits),
        .fifo_depth_log (fifo_depth_log),
        .chan_len       (chan_len),
        .base           (base_addr[i*addr_bits +: addr_bits])
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .write    (write[i]),
        .in       (in[i*val_bits +: val_bits]),
        .pop      (grant[i]),
        .full     (full[i]),
        .req      (req[i]),
        .head     (head[i]),
        .addr     (addr[i]),
        .done     (done[i]),
        .overflow (overflow[i])
      );
    end
  endgenerate

  // Round-robin pick: first requesting channel at or after ptr, modulo channel_num.
  always_comb begin
    gvld = 1'b0;
    gidx = ptr;
    scan = '0;
    for (int k = 0; k < channel_num; k++) begin
      scan = ptr + channel_num_log'(k);
      if (!gvld && req[scan]) begin
        gvld = 1'b1;
        gidx = scan;
      end
    end
  end

  assign grant    = gvld ? ({{(channel_num-1){1'b0}}, 1'b1} << gidx) : '0;
  assign all_done = &done;

  // Registered RAM port and arbiter pointer; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ptr      <= '0;
    end else begin
      ram_we <= gvld;
      if (gvld) begin
        ram_addr <= addr[gidx];
        ram_din  <= head[gidx];
        ptr      <= gidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_value_writer.sv
// Bench for value_writer: two instances (chan_len 1024 and 4) share stimulus;
// a queue-based model predicts every output each cycle, and directed
// literal checks pin the model to hand-computed values.
`timescale 1ns/1ps
module tb_value_writer;
  localparam int N = 8, VB = 8, AB = 13;
  localparam logic [N*AB-1:0] BASE =
    {13'd8190, 13'd600, 13'd500, 13'd400, 13'd300, 13'd200, 13'd100, 13'd0};
`ifdef VALUE_WRITER_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  wr = '0;
  logic [N*VB-1:0] din_v = '0;

  logic [N-1:0]  full_o [2];
  logic [N-1:0]  done_o [2];
  logic [N-1:0]  ovf_o  [2];
  logic          we_o   [2];
  logic          alld_o [2];
  logic [AB-1:0] addr_o [2];
  logic [VB-1:0] data_o [2];

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  value_writer #(.base_addr(BASE), .chan_len(1024)) dut0 (
    .clk(clk), .rst(rst), .write(wr), .in(din_v), .full(full_o[0]),
    .ram_we(we_o[0]), .ram_addr(addr_o[0]), .ram_din(data_o[0]),
    .done(done_o[0]), .all_done(alld_o[0]), .overflow(ovf_o[0]));

  value_writer #(.base_addr(BASE), .chan_len(4)) dut1 (
    .clk(clk), .rst(rst), .write(wr), .in(din_v), .full(full_o[1]),
    .ram_we(we_o[1]), .ram_addr(addr_o[1]), .ram_din(data_o[1]),
    .done(done_o[1]), .all_done(alld_o[1]), .overflow(ovf_o[1]));

  // ---------------- behavioural model ----------------
  logic [7:0] q [2*N][$];
  int m_cnt [2][N];
  bit m_done [2][N];
  bit m_ovf [2][N];
  int m_ptr [2];
  bit m_we [2];
  int m_addr [2];
  int m_din [2];

  function automatic int base_of(input int i);
    return (i == 7) ? 8190 : i * 100;
  endfunction

  function automatic int len_of(input int k);
    return (k == 0) ? 1024 : 4;
  endfunction

  task automatic model_step();
    int g, c;
    bit fp [N];
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          q[k*N+i].delete();
          m_cnt[k][i] = 0; m_done[k][i] = 0; m_ovf[k][i] = 0;
        end
        m_ptr[k] = 0; m_we[k] = 0; m_addr[k] = 0; m_din[k] = 0;
      end else begin
        for (int i = 0; i < N; i++) fp[i] = (q[k*N+i].size() == 16);
        g = -1;
        for (int s = 0; s < N; s++) begin
          c = (m_ptr[k] + s) % N;
          if (g < 0 && q[k*N+c].size() != 0 && !m_done[k][c]) g = c;
        end
        if (g >= 0) begin
          m_we[k]   = 1;
          m_addr[k] = (base_of(g) + m_cnt[k][g]) % 8192;
          m_din[k]  = int'(q[k*N+g].pop_front());
          m_cnt[k][g]++;
          if (m_cnt[k][g] == len_of(k)) m_done[k][g] = 1;
          m_ptr[k] = (g + 1) % N;
        end else begin
          m_we[k] = 0;
        end
        for (int i = 0; i < N; i++)
          if (wr[i]) begin
            if (!fp[i]) q[k*N+i].push_back(din_v[i*VB +: VB]);
            else        m_ovf[k][i] = 1;
          end
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] e_full, e_done, e_ovf;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < N; i++) begin
          e_full[i] = (q[k*N+i].size() == 16);
          e_done[i] = m_done[k][i];
          e_ovf[i]  = OVF & m_ovf[k][i];
        end
        n_chk++;
        if (we_o[k] !== m_we[k] || addr_o[k] !== AB'(m_addr[k]) || data_o[k] !== VB'(m_din[k])) begin
          n_fail++;
          $display("FAIL ram_port inst%0d t=%0t got we=%b addr=%0d din=%h, expected we=%b addr=%0d din=%h",
                   k, $time, we_o[k], addr_o[k], data_o[k], m_we[k], m_addr[k], m_din[k]);
        end
        n_chk++;
        if (full_o[k] !== e_full || done_o[k] !== e_done || ovf_o[k] !== e_ovf || alld_o[k] !== (&e_done)) begin
          n_fail++;
          $display("FAIL flags inst%0d t=%0t got full=%b done=%b ovf=%b all=%b, expected full=%b done=%b ovf=%b all=%b",
                   k, $time, full_o[k], done_o[k], ovf_o[k], alld_o[k], e_full, e_done, e_ovf, &e_done);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d (0x%h) expected %0d (0x%h)", name, got, got, exp, exp);
    end
  endtask

  // Apply inputs, let one edge happen, advance model, return at the next negedge.
  task automatic tick(input logic [N-1:0] w, input logic [N*VB-1:0] d);
    wr = w; din_v = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pushv(input int ch, input logic [7:0] v);
    logic [N*VB-1:0] d;
    d = '0;
    d[ch*VB +: VB] = v;
    tick(N'(1) << ch, d);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick('0, '0);
    rst = 1'b1;
  endtask

  int exp_a [8] = '{0, 100, 200, 300, 400, 500, 600, 8190};
  int wrap_a [4] = '{8190, 8191, 0, 1};
  logic [N*VB-1:0] all_d;

  initial begin
    // Reset state
    @(negedge clk);
    rst = 1'b0;
    tick('0, '0);
    chk_en = 1'b1;
    tick('0, '0);
    check("reset_we", we_o[0], 0);
    check("reset_addr", addr_o[0], 0);
    check("reset_din", data_o[0], 0);
    check("reset_full", full_o[0], 0);
    check("reset_done", done_o[1], 0);
    rst = 1'b1;

    // Single push on channel 3
    pushv(3, 8'hA5);
    check("single_we_early", we_o[0], 0);
    tick('0, '0);
    check("single_we", we_o[0], 1);
    check("single_addr", addr_o[0], 300);
    check("single_din", data_o[0], 8'hA5);
    check("single_addr_b", addr_o[1], 300);
    tick('0, '0);
    check("single_we_off", we_o[0], 0);

    // All channels push value i together; drain in order 0..7
    do_reset();
    for (int i = 0; i < N; i++) all_d[i*VB +: VB] = VB'(i);
    tick('1, all_d);
    for (int i = 0; i < N; i++) begin
      tick('0, '0);
      check("rr_we", we_o[0], 1);
      check("rr_din", data_o[0], i);
      check("rr_addr", addr_o[0], exp_a[i]);
    end
    tick('0, '0);
    check("rr_idle", we_o[0], 0);
    // ptr back at 0: channel 0 wins over 7
    all_d = '0; all_d[0 +: VB] = 8'h11; all_d[7*VB +: VB] = 8'h77;
    tick(8'h81, all_d);
    tick('0, '0);
    check("ptr_first", data_o[0], 8'h11);
    tick('0, '0);
    check("ptr_second", data_o[0], 8'h77);
    check("ptr_second_addr", addr_o[0], 8191);

    // Channel 0 stream of 20; short region on dut1 fills FIFO then overflows
    do_reset();
    for (int n = 0; n < 20; n++) begin
      pushv(0, 8'(8'h10 + n));
      if (n >= 1) begin
        check("stream_addr", addr_o[0], n - 1);
        check("stream_din", data_o[0], 8'h10 + n - 1);
      end
    end
    check("stream_full_b", full_o[1][0], 1);
    check("stream_done_b", done_o[1][0], 1);
    check("stream_ovf_b_pre", ovf_o[1][0], 0);
    pushv(0, 8'hEE);
    check("stream_ovf_b", ovf_o[1][0], OVF);
    check("stream_full_a", full_o[0][0], 0);
    tick('0, '0);
    check("stream_tail_addr", addr_o[0], 20);
    tick('0, '0);

    // Overflow on channel 1: 4 written, 16 buffered, one more dropped
    do_reset();
    for (int n = 0; n < 21; n++) pushv(1, 8'(8'h30 + n));
    check("ovf1_full", full_o[1][1], 1);
    check("ovf1_flag", ovf_o[1][1], OVF);
    for (int n = 0; n < 3; n++) tick('0, '0);
    check("ovf1_sticky", ovf_o[1][1], OVF);
    check("ovf1_none_a", ovf_o[0], 0);

    // chan_len=4 region on channel 5
    do_reset();
    for (int t = 0; t < 10; t++) begin
      if (t < 6) pushv(5, 8'(8'h50 + t)); else tick('0, '0);
      if (t >= 1 && t <= 4) begin
        check("len4_we", we_o[1], 1);
        check("len4_addr", addr_o[1], 500 + t - 1);
        check("len4_din", data_o[1], 8'h50 + t - 1);
      end
      if (t == 3) check("len4_done_pre", done_o[1][5], 0);
      if (t == 4) check("len4_done", done_o[1][5], 1);
      if (t >= 5) check("len4_no_more", we_o[1], 0);
    end

    // Address wrap on channel 7 (base 8190)
    do_reset();
    for (int t = 0; t < 6; t++) begin
      if (t < 4) pushv(7, 8'(8'h70 + t)); else tick('0, '0);
      if (t >= 1 && t <= 4) check("wrap_addr", addr_o[1], wrap_a[t-1]);
    end

    // Full contention: every channel pushes every cycle
    do_reset();
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < N; i++) all_d[i*VB +: VB] = VB'(i * 16 + n);
      tick('1, all_d);
    end
    for (int n = 0; n < 40; n++) tick('0, '0);
    check("contend_alldone_b", alld_o[1], 1);
    check("contend_alldone_a", alld_o[0], 0);

    // Reset mid-burst with data buffered on channel 2
    do_reset();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < N; i++) all_d[i*VB +: VB] = VB'(8'hA0 + n);
      tick('1, all_d);
    end
    rst = 1'b0;
    tick('0, '0);
    check("midrst_we", we_o[0], 0);
    check("midrst_full", full_o[0], 0);
    rst = 1'b1;
    tick('0, '0);
    check("midrst_idle", we_o[0], 0);
    pushv(2, 8'hC3);
    tick('0, '0);
    check("midrst_we2", we_o[0], 1);
    check("midrst_addr", addr_o[0], 200);
    check("midrst_din", data_o[0], 8'hC3);
    tick('0, '0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/value_writer.md
Name: value_writer

Overview:
- Write-side counterpart of the per-channel value FIFO fetch path.
- Accepts values from channel_num producer channels, each through a write/in/full handshake, and buffers them in per-channel FIFOs.
- A round-robin arbiter drains the FIFOs into one single-port result RAM write port, at most one word per cycle.
- Each channel owns a contiguous RAM region (base address + length); per-channel done flags signal region completion.

Parameters:
- channel_num, 8, number of producer channels (power of 2, >=2)
- channel_num_log, 3, log2(channel_num)
- val_bits, 8, data width per value
- addr_bits, 13, RAM address width
- fifo_depth_log, 4, log2 of per-channel FIFO depth (depth 16)
- base_addr, {8{13'd0}}, packed channel_num*addr_bits vector; channel i base at [i*addr_bits+:addr_bits]
- chan_len, 1024, words per channel region (1..2^addr_bits)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- write  input  channel_num  per-channel push strobe
- in  input  val_bits*channel_num  per-channel data; channel i at [i*val_bits+:val_bits]
- full  output  channel_num  per-channel FIFO full (count==depth)
- ram_we  output  1  registered RAM write enable
- ram_addr  output  addr_bits  registered RAM address
- ram_din  output  val_bits  registered RAM data
- done  output  channel_num  sticky: channel wrote chan_len words
- all_done  output  1  &done
- overflow  output  channel_num  sticky push-while-full flag (see Optional Feature)

Behaviour:
- Reset (rst==0 at an edge):
  - all FIFOs emptied (full=0)
  - ram_we=0, ram_addr=0, ram_din=0
  - done=0, overflow=0
  - arbiter pointer ptr=0
  - addr[i]=base_addr[i], cnt[i]=0
  - Reset mid-operation discards buffered data and any data in flight; no RAM write occurs on the reset edge.
- Push:
  - write[i] && !full[i] at an edge stores in[i] in FIFO i.
  - write[i] && full[i]: data dropped, even if FIFO i is popped the same cycle.
  - full reflects registered count, updated the edge after a push or pop.
- Arbitration, every edge:
  - candidate set = channels with non-empty FIFO and done[i]==0.
  - grant g = first candidate scanning ptr, ptr+1, ... modulo channel_num.
  - If a grant exists:
    - pop FIFO g; ram_we<=1, ram_addr<=addr[g], ram_din<=head of g
    - addr[g]<=addr[g]+1 (wraps modulo 2^addr_bits)
    - cnt[g]<=cnt[g]+1
    - ptr<=g+1 mod channel_num
  - No candidate: ram_we<=0, ptr unchanged.
- Latency: a value pushed at edge E appears on the RAM port after edge E+1 at the earliest (with no contention). Worst case under full contention is E+channel_num.
- Simultaneous push and pop on the same FIFO: both occur; count unchanged.
- Completion:
  - When cnt[g] reaches chan_len on a grant, done[g]<=1 on that same edge.
  - Channel g is then excluded from arbitration. Its FIFO still accepts pushes until full; that data is never written.
  - done clears only on reset.
- Ordering: per-channel RAM writes are strictly FIFO order at consecutive addresses. Cross-channel order follows round-robin.

Optional Feature:
- Macro: VALUE_WRITER_OVERFLOW_EN.
- Defined: overflow[i] sets (sticky until reset) on any edge with write[i] && full[i].
- Undefined: no overflow logic is built; overflow is tied to 0. All other behaviour is identical.

Test Plan:
- Reset then single push, channel 3 value 8'hA5, base_addr[3]=13'd300 -> next cycle ram_we=1, ram_addr=300, ram_din=A5; following cycle ram_we=0.
- All 8 channels push value i in the same cycle, ptr=0 -> 8 consecutive RAM writes in channel order 0..7, each at base_addr[i]; ptr returns to 0.
- Channel 0 pushes 20 values with no other traffic -> full[0]=1 after 16 buffered, minus any already drained. Pushes while full are dropped. RAM sees an uninterrupted address sequence with no gaps or duplicates.
- chan_len=4, channel 5 pushes 6 values -> exactly 4 writes at base..base+3; done[5]=1 on the 4th write edge; no further writes for channel 5.
- Reset asserted mid-burst with 3 values buffered on channel 2 -> ram_we=0 next cycle, full=0, addr[2] back to base; a new push writes at base.
- With VALUE_WRITER_OVERFLOW_EN: fill channel 1 to 16, push once more -> overflow[1]=1 and stays high. Without the macro, the same stimulus leaves overflow=0.
